ysyx_22040127_trap_ctrl: RTL and testbench
==========================================

# ysyx_22040127_trap_ctrl

Machine-mode trap sequencer for the 5-stage RV64 core. It sits beside the writeback/register-file stage and watches committing instructions for `ecall`, `mret` and, optionally, the machine timer interrupt. When one is taken, it flushes the pipeline, writes `mepc` and `mcause` through a dedicated CSR write port, and updates `mstatus` through save/restore strobes. It then issues a PC redirect to fetch over a valid/ready handshake.

## Interface
- `XLEN`, 64, CSR data width.
- `PC_W`, 32, PC width; PCs are zero-extended to `XLEN` on CSR writes.
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-low.
- `wb_valid` input 1: instruction committing in WB this cycle.
- `wb_pc` input PC_W: PC of the committing instruction.
- `wb_npc` input PC_W: architectural next PC of the committing instruction.
- `wb_ecall` input 1: committing instruction is `ecall`.
- `wb_mret` input 1: committing instruction is `mret`.
- `timer_irq` input 1: level machine-timer interrupt request.
- `csr_mtvec` input XLEN: current `mtvec`.
- `csr_mepc` input XLEN: current `mepc`.
- `csr_mie` input XLEN: current `mie`.
- `mstatus_mie` input 1: current `mstatus.MIE`.
- `trap_csr_we` output 1: CSR write strobe, one cycle.
- `trap_csr_addr` output 12: CSR address, `0x341` or `0x342`.
- `trap_csr_wdata` output XLEN: CSR write data.
- `trap_mstatus_save` output 1: pulse; `mpie<=mie`, `mie<=0`, `mpp<=2'b11`.
- `trap_mstatus_restore` output 1: pulse; `mie<=mpie`, `mpie<=1`, `mpp<=2'b11`.
- `flush` output 1: kill all younger in-flight instructions and suppress GPR write.
- `busy` output 1: controller not idle.
- `redirect_valid` output 1: redirect request to fetch.
- `redirect_pc` output PC_W: redirect target.
- `redirect_ready` input 1: fetch accepts the redirect.

## Operation
- States: `IDLE`, `WR_EPC`, `WR_CAUSE`, `REDIRECT`.
- `IDLE` event priority when `wb_valid`=1: `ecall` > `mret` > interrupt.
  - `ecall`: latch `epc=wb_pc`, `cause=11`, `vec=0`; go to `WR_EPC`.
  - `mret`: latch `target=csr_mepc[PC_W-1:0]`; pulse `trap_mstatus_restore` next cycle; go to `REDIRECT`.
  - Interrupt taken iff `timer_irq & csr_mie[7] & mstatus_mie`: latch `epc=wb_npc`, `cause={1'b1,63'd7}`, `vec=1`; go to `WR_EPC`.
  - The WB instruction itself always commits normally; the `ecall` GPR write is a no-op.
- `WR_EPC`: `trap_csr_we=1`, `addr=0x341`, `wdata={0,epc}`; go to `WR_CAUSE`.
- `WR_CAUSE`: `trap_csr_we=1`, `addr=0x342`, `wdata=cause`; pulse `trap_mstatus_save`; latch target; go to `REDIRECT`.
- Target computation:
  - `base = csr_mtvec & ~3`.
  - If `csr_mtvec[1:0]==1` and `vec`: `base + 4*cause[5:0]`.
  - Otherwise `base`.
  - Truncate to `PC_W`.
- `REDIRECT`: `redirect_valid=1`, `redirect_pc=target`; on `redirect_ready` go to `IDLE`.
- `flush` and `busy` equal (state != `IDLE`).
- While not `IDLE`, `wb_valid` events are ignored. The bench asserts that none occur.
- `wb_ecall` and `wb_mret` both high is illegal; `ecall` wins.

## Timing
- All outputs are registered from state and latched fields.
- Reset values: every output 0; state `IDLE`.
- Reset is asynchronous and can assert mid-sequence. It drops all strobes immediately, and no partial CSR write completes afterwards.
- `ecall` or interrupt seen at cycle T:
  - `flush`/`busy` from T+1.
  - `mepc` write at T+1.
  - `mcause` write and save pulse at T+2.
  - `redirect_valid` from T+3.
  - With ready=1 at T+3, `IDLE` at T+4.
- `mret` at T: restore pulse and `redirect_valid` at T+1; `IDLE` at T+2 if ready.
- `redirect_valid` stays high and `redirect_pc` stays stable until the cycle after `redirect_ready`; there is no timeout.
- CSR-instruction writes from WB never coincide with trap writes, because WB is flushed while `busy`.

## Configuration
- `TRAP_TIMER_IRQ_EN` defined: interrupt path and vectored mode compiled in.
- `TRAP_TIMER_IRQ_EN` undefined:
  - `timer_irq` and `csr_mie` are unused.
  - `vec` is forced to 0.
  - Redirect always goes to `base`.

## Structure
- Shared package contents:
  - State enum.
  - CSR address constants `0x341`/`0x342`/`0x300`/`0x305`/`0x304`.
  - Cause codes `CAUSE_ECALL_M=11` and `CAUSE_MTI={1,63'd7}`.
- One sub-module, `ysyx_22040127_trap_vec`: combinational target calculation from `mtvec`, `cause` and `vec`.

## Test plan
- `ecall` at `wb_pc=0x8000_0010`, `mtvec=0x8000_1000`, ready=1:
  - T+1: `mepc` write `0x8000_0010`.
  - T+2: `mcause` write 11 plus save pulse.
  - T+3: redirect to `0x8000_1000`.
  - T+4: `busy=0`.
- `mret` with `csr_mepc=0x8000_0014`: T+1 restore pulse and redirect `0x8000_0014`; no CSR write.
- `redirect_ready` held 0 for 5 cycles: `redirect_valid`=1 and `redirect_pc` constant throughout; `IDLE` one cycle after ready rises.
- Macro on, irq=1, `mie[7]`=1, `MIE`=1, `wb_npc=0x8000_0020`, `mtvec=0x8000_1001`:
  - `mepc=0x8000_0020`, `mcause=0x8000_0000_0000_0007`, target `0x8000_101C`.
  - Same stimulus with `MIE`=0: no response.
- `ecall` and irq in the same cycle: `cause=11`, target `base`.
- `rst` low during `WR_CAUSE`: all outputs 0 asynchronously; no `mcause` write; `IDLE` after release.

Source files
------------

// File: rtl/ysyx_22040127_trap_ctrl_pkg.sv
// rtl/ysyx_22040127_trap_ctrl_pkg.sv - shared states, CSR addresses and cause codes for the trap sequencer
package ysyx_22040127_trap_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_EPC   = 2'd1,
    ST_WR_CAUSE = 2'd2,
    ST_REDIRECT = 2'd3
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [63:0] CAUSE_ECALL_M = 64'd11;
  localparam logic [63:0] CAUSE_MTI     = {1'b1, 63'd7};

endpackage

// File: rtl/ysyx_22040127_trap_ctrl_if.sv
// rtl/ysyx_22040127_trap_ctrl_if.sv - PC redirect handshake from the trap sequencer to fetch
interface ysyx_22040127_trap_ctrl_if #(
  parameter int PC_W = 32
);
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            redirect_ready;

  modport master (
    output redirect_valid,
    output redirect_pc,
    input  redirect_ready
  );

  modport slave (
    input  redirect_valid,
    input  redirect_pc,
    output redirect_ready
  );
endinterface

// File: rtl/ysyx_22040127_trap_vec.sv
// rtl/ysyx_22040127_trap_vec.sv - combinational trap target from mtvec, cause and vectored flag
module ysyx_22040127_trap_vec #(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic [XLEN-1:0] mtvec,
  input  logic [XLEN-1:0] cause,
  input  logic            vec,
  output logic [PC_W-1:0] target
);
  logic [PC_W-1:0] base;
  logic [PC_W-1:0] offset;
  logic            unused_bits;

  assign base   = {mtvec[PC_W-1:2], 2'b00};
  assign offset = {{(PC_W-8){1'b0}}, cause[5:0], 2'b00};
  assign target = (vec && (mtvec[1:0] == 2'b01)) ? base + offset : base;

  assign unused_bits = ^{mtvec[XLEN-1:PC_W], cause[XLEN-1:6]};
endmodule

// File: rtl/ysyx_22040127_trap_ctrl.sv
// rtl/ysyx_22040127_trap_ctrl.sv - M-mode trap sequencer (ecall, mret; timer irq and vectored mode under TRAP_TIMER_IRQ_EN)
module ysyx_22040127_trap_ctrl
  import ysyx_22040127_trap_ctrl_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int PC_W = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_valid,
  input  logic [PC_W-1:0]           wb_pc,
  input  logic [PC_W-1:0]           wb_npc,
  input  logic                      wb_ecall,
  input  logic                      wb_mret,
  input  logic                      timer_irq,
  input  logic [XLEN-1:0]           csr_mtvec,
  input  logic [XLEN-1:0]           csr_mepc,
  input  logic [XLEN-1:0]           csr_mie,
  input  logic                      mstatus_mie,
  output logic                      trap_csr_we,
  output logic [11:0]               trap_csr_addr,
  output logic [XLEN-1:0]           trap_csr_wdata,
  output logic                      trap_mstatus_save,
  output logic                      trap_mstatus_restore,
  output logic                      flush,
  output logic                      busy,
  ysyx_22040127_trap_ctrl_if.master redir
);
  trap_state_e     state, state_next;
  logic [XLEN-1:0] cause_q, cause_n;
  logic            vec_q, vec_n;
  logic            csr_we_n, save_n, restore_n, rv_n;
  logic [11:0]     csr_addr_n;
  logic [XLEN-1:0] csr_wdata_n;
  logic [PC_W-1:0] rpc_n;
  logic [PC_W-1:0] vec_target;
  logic            irq_take;
  logic            vec_eff;
  logic            unused_in;

`ifdef TRAP_TIMER_IRQ_EN
  assign irq_take  = timer_irq & csr_mie[7] & mstatus_mie;
  assign vec_eff   = vec_q;
  assign unused_in = ^{csr_mie[XLEN-1:8], csr_mie[6:0], csr_mepc[XLEN-1:PC_W]};
`else
  assign irq_take  = 1'b0;
  assign vec_eff   = 1'b0;
  assign unused_in = ^{timer_irq, csr_mie, mstatus_mie, vec_q, csr_mepc[XLEN-1:PC_W]};
`endif

  ysyx_22040127_trap_vec #(
    .XLEN(XLEN),
    .PC_W(PC_W)
  ) u_trap_vec (
    .mtvec (csr_mtvec),
    .cause (cause_q),
    .vec   (vec_eff),
    .target(vec_target)
  );

  // Outputs are computed for the state being entered and registered with it,
  // so each strobe is glitch-free and aligned to its state.
  always_comb begin
    state_next  = state;
    cause_n     = cause_q;
    vec_n       = vec_q;
    csr_we_n    = 1'b0;
    csr_addr_n  = 12'h000;
    csr_wdata_n = '0;
    save_n      = 1'b0;
    restore_n   = 1'b0;
    rv_n        = 1'b0;
    rpc_n       = '0;
    unique case (state)
      ST_IDLE: begin
        if (wb_valid) begin
          if (wb_ecall) begin
            state_next  = ST_WR_EPC;
            cause_n     = XLEN'(CAUSE_ECALL_M);
            vec_n       = 1'b0;
            csr_we_n    = 1'b1;
            csr_addr_n  = CSR_MEPC;
            csr_wdata_n = {{(XLEN-PC_W){1'b0}}, wb_pc};
          end else if (wb_mret) begin
            state_next = ST_REDIRECT;
            restore_n  = 1'b1;
            rv_n       = 1'b1;
            rpc_n      = csr_mepc[PC_W-1:0];
          end else if (irq_take) begin
            state_next  = ST_WR_EPC;
            cause_n     = XLEN'(CAUSE_MTI);
            vec_n       = 1'b1;
            csr_we_n    = 1'b1;
            csr_addr_n  = CSR_MEPC;
            csr_wdata_n = {{(XLEN-PC_W){1'b0}}, wb_npc};
          end
        end
      end
      ST_WR_EPC: begin
        state_next  = ST_WR_CAUSE;
        csr_we_n    = 1'b1;
        csr_addr_n  = CSR_MCAUSE;
        csr_wdata_n = cause_q;
        save_n      = 1'b1;
      end
      ST_WR_CAUSE: begin
        state_next = ST_REDIRECT;
        rv_n       = 1'b1;
        rpc_n      = vec_target;
      end
      ST_REDIRECT: begin
        if (redir.redirect_ready) begin
          state_next = ST_IDLE;
        end else begin
          rv_n  = 1'b1;
          rpc_n = redir.redirect_pc;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                <= ST_IDLE;
      cause_q              <= '0;
      vec_q                <= 1'b0;
      trap_csr_we          <= 1'b0;
      trap_csr_addr        <= 12'h000;
      trap_csr_wdata       <= '0;
      trap_mstatus_save    <= 1'b0;
      trap_mstatus_restore <= 1'b0;
      flush                <= 1'b0;
      busy                 <= 1'b0;
      redir.redirect_valid <= 1'b0;
      redir.redirect_pc    <= '0;
    end else begin
      state                <= state_next;
      cause_q              <= cause_n;
      vec_q                <= vec_n;
      trap_csr_we          <= csr_we_n;
      trap_csr_addr        <= csr_addr_n;
      trap_csr_wdata       <= csr_wdata_n;
      trap_mstatus_save    <= save_n;
      trap_mstatus_restore <= restore_n;
      flush                <= (state_next != ST_IDLE);
      busy                 <= (state_next != ST_IDLE);
      redir.redirect_valid <= rv_n;
      redir.redirect_pc    <= rpc_n;
    end
  end
endmodule

// File: tb/tb_ysyx_22040127_trap_ctrl.sv
// tb/tb_ysyx_22040127_trap_ctrl.sv - self-checking bench for the trap sequencer
module tb_ysyx_22040127_trap_ctrl;
  localparam logic [63:0] MTI = {1'b1, 63'd7};

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic        save;
    logic        restore;
    logic        flush;
    logic        busy;
    logic        rv;
    logic [31:0] rpc;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wb_valid = 1'b0, wb_ecall = 1'b0, wb_mret = 1'b0, timer_irq = 1'b0;
  logic [31:0] wb_pc = '0, wb_npc = '0;
  logic [63:0] csr_mtvec = '0, csr_mepc = '0, csr_mie = '0;
  logic        mstatus_mie = 1'b0;
  logic        trap_csr_we, trap_mstatus_save, trap_mstatus_restore, flush, busy;
  logic [11:0] trap_csr_addr;
  logic [63:0] trap_csr_wdata;

  ysyx_22040127_trap_ctrl_if #(.PC_W(32)) rif ();

  ysyx_22040127_trap_ctrl dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_npc(wb_npc),
    .wb_ecall(wb_ecall), .wb_mret(wb_mret), .timer_irq(timer_irq),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mie(csr_mie), .mstatus_mie(mstatus_mie),
    .trap_csr_we(trap_csr_we), .trap_csr_addr(trap_csr_addr), .trap_csr_wdata(trap_csr_wdata),
    .trap_mstatus_save(trap_mstatus_save), .trap_mstatus_restore(trap_mstatus_restore),
    .flush(flush), .busy(busy), .redir(rif)
  );

  always #5 clk = ~clk;

  obs_t        exp_q[$];
  int          checks = 0, failures = 0;
  bit          cmp_en = 1'b1;
  int          mepc_cnt = 0, mcause_cnt = 0, redir_cnt = 0;
  logic [63:0] mepc_seen = '0, mcause_seen = '0;
  logic [31:0] redir_seen = '0;

  function automatic obs_t actual();
    obs_t a;
    a.we      = trap_csr_we;
    a.addr    = trap_csr_we ? trap_csr_addr : 12'h000;
    a.wdata   = trap_csr_we ? trap_csr_wdata : 64'h0;
    a.save    = trap_mstatus_save;
    a.restore = trap_mstatus_restore;
    a.flush   = flush;
    a.busy    = busy;
    a.rv      = rif.redirect_valid;
    a.rpc     = rif.redirect_valid ? rif.redirect_pc : 32'h0;
    return a;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Per-cycle comparison against the model's expected trace; idle when the trace is empty.
  always @(negedge clk) begin
    if (rst && cmp_en) begin
      obs_t e, a;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : obs_t'('0);
      a = actual();
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle_outputs t=%0t actual=%h required=%h", $time, a, e);
      end
      if (wb_valid && busy) begin
        failures++;
        $display("FAIL wb_while_busy t=%0t", $time);
      end
    end
  end

  // What the CSR file and fetch would observe at each clock edge.
  always @(posedge clk) begin
    if (rst) begin
      if (trap_csr_we && trap_csr_addr == 12'h341) begin mepc_seen = trap_csr_wdata; mepc_cnt++; end
      if (trap_csr_we && trap_csr_addr == 12'h342) begin mcause_seen = trap_csr_wdata; mcause_cnt++; end
      if (rif.redirect_valid && rif.redirect_ready) begin redir_seen = rif.redirect_pc; redir_cnt++; end
    end
  end

  task automatic model(input bit ecall, input bit mret, input bit irq, input bit mie7, input bit mmie,
                       input logic [31:0] pc, input logic [31:0] npc, input logic [63:0] mepc,
                       input logic [63:0] mtvec, input int stall, output int n, output int r0);
    obs_t o;
    bit trap, vec;
    logic [63:0] epc, cause, base, tgt;
    trap = 0; vec = 0; epc = 0; cause = 0;
    exp_q.push_back(obs_t'('0));
    n = 1; r0 = 0;
    if (ecall) begin
      trap = 1; epc = {32'h0, pc}; cause = 64'd11;
    end else if (mret) begin
      r0 = 1;
      for (int i = 0; i <= stall; i++) begin
        o = '0; o.busy = 1; o.flush = 1; o.rv = 1; o.rpc = mepc[31:0]; o.restore = (i == 0);
        exp_q.push_back(o); n++;
      end
    end
`ifdef TRAP_TIMER_IRQ_EN
    if (!ecall && !mret && irq && mie7 && mmie) begin
      trap = 1; epc = {32'h0, npc}; cause = MTI; vec = 1;
    end
`endif
    if (trap) begin
      base = mtvec & ~64'h3;
      tgt  = (vec && mtvec[1:0] == 2'd1) ? base + 4 * (cause % 64) : base;
      o = '0; o.busy = 1; o.flush = 1; o.we = 1; o.addr = 12'h341; o.wdata = epc;
      exp_q.push_back(o);
      o = '0; o.busy = 1; o.flush = 1; o.we = 1; o.addr = 12'h342; o.wdata = cause; o.save = 1;
      exp_q.push_back(o);
      for (int i = 0; i <= stall; i++) begin
        o = '0; o.busy = 1; o.flush = 1; o.rv = 1; o.rpc = tgt[31:0];
        exp_q.push_back(o);
      end
      n = 4 + stall; r0 = 3;
    end
  endtask

  task automatic do_event(input bit ecall, input bit mret, input bit irq, input bit mie7, input bit mmie,
                          input logic [31:0] pc, input logic [31:0] npc, input logic [63:0] mepc,
                          input logic [63:0] mtvec, input int stall);
    int n, r0;
    @(posedge clk); #1;
    wb_valid = 1; wb_ecall = ecall; wb_mret = mret; timer_irq = irq;
    csr_mie = {56'h0, mie7, 7'h0}; mstatus_mie = mmie;
    wb_pc = pc; wb_npc = npc; csr_mepc = mepc; csr_mtvec = mtvec;
    rif.redirect_ready = (stall == 0);
    model(ecall, mret, irq, mie7, mmie, pc, npc, mepc, mtvec, stall, n, r0);
    for (int j = 1; j <= n; j++) begin
      @(posedge clk); #1;
      wb_valid = 0; wb_ecall = 0; wb_mret = 0; timer_irq = 0;
      if (stall > 0 && j == r0 + stall) rif.redirect_ready = 1;
    end
    rif.redirect_ready = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    int c_mepc, c_mcause, c_redir;
    rif.redirect_ready = 1;
    #1;
    check("reset_outputs", 64'(actual()), 64'h0);
    check("reset_busy", {63'h0, busy}, 64'h0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1;
    @(posedge clk); #1;

    do_event(1, 0, 0, 0, 0, 32'h8000_0010, 32'h8000_0014, 64'h0, 64'h8000_1000, 0);
    check("ecall_mepc", mepc_seen, 64'h8000_0010);
    check("ecall_mcause", mcause_seen, 64'd11);
    check("ecall_target", {32'h0, redir_seen}, 64'h8000_1000);

    c_mepc = mepc_cnt; c_mcause = mcause_cnt;
    do_event(0, 1, 0, 0, 0, 32'h8000_0100, 32'h8000_0104, 64'h8000_0014, 64'h8000_1000, 0);
    check("mret_target", {32'h0, redir_seen}, 64'h8000_0014);
    check("mret_no_csr_write", 64'(mepc_cnt + mcause_cnt), 64'(c_mepc + c_mcause));

    c_redir = redir_cnt;
    do_event(1, 0, 0, 0, 0, 32'h8000_0200, 32'h8000_0204, 64'h0, 64'h8000_2000, 5);
    check("stall_target", {32'h0, redir_seen}, 64'h8000_2000);
    check("stall_single_accept", 64'(redir_cnt), 64'(c_redir + 1));
    do_event(0, 1, 0, 0, 0, 32'h8000_0300, 32'h8000_0304, 64'h8000_0400, 64'h8000_2000, 3);

    c_mepc = mepc_cnt; c_redir = redir_cnt;
    do_event(0, 0, 1, 1, 1, 32'h8000_001C, 32'h8000_0020, 64'h0, 64'h8000_1001, 0);
`ifdef TRAP_TIMER_IRQ_EN
    check("irq_mepc", mepc_seen, 64'h8000_0020);
    check("irq_mcause", mcause_seen, 64'h8000_0000_0000_0007);
    check("irq_target", {32'h0, redir_seen}, 64'h8000_101C);
`else
    check("irq_disabled_no_write", 64'(mepc_cnt), 64'(c_mepc));
    check("irq_disabled_no_redirect", 64'(redir_cnt), 64'(c_redir));
`endif

    c_mepc = mepc_cnt; c_redir = redir_cnt;
    do_event(0, 0, 1, 1, 0, 32'h8000_001C, 32'h8000_0020, 64'h0, 64'h8000_1001, 0);
    check("irq_masked_no_write", 64'(mepc_cnt), 64'(c_mepc));
    check("irq_masked_no_redirect", 64'(redir_cnt), 64'(c_redir));

    do_event(1, 0, 1, 1, 1, 32'h8000_0030, 32'h8000_0034, 64'h0, 64'h8000_1001, 0);
    check("ecall_irq_mepc", mepc_seen, 64'h8000_0030);
    check("ecall_irq_mcause", mcause_seen, 64'd11);
    check("ecall_irq_target", {32'h0, redir_seen}, 64'h8000_1000);

    do_event(1, 1, 0, 0, 0, 32'h8000_0040, 32'h8000_0044, 64'h8000_0500, 64'h8000_3000, 0);
    check("ecall_mret_cause", mcause_seen, 64'd11);
    check("ecall_mret_target", {32'h0, redir_seen}, 64'h8000_3000);

    // Reset pulled while the mcause write strobe is up.
    begin
      int n, r0;
      @(posedge clk); #1;
      wb_valid = 1; wb_ecall = 1; wb_pc = 32'h8000_0050; csr_mtvec = 64'h8000_1000;
      rif.redirect_ready = 1;
      model(1, 0, 0, 0, 0, 32'h8000_0050, 32'h8000_0054, 64'h0, 64'h8000_1000, 0, n, r0);
      @(posedge clk); #1;
      wb_valid = 0; wb_ecall = 0;
      @(posedge clk); #1;
      @(negedge clk); #2;
      c_mcause = mcause_cnt;
      cmp_en = 0;
      rst = 0;
      #1;
      check("async_reset_outputs", 64'(actual()), 64'h0);
      exp_q.delete();
      @(posedge clk); #1;
      check("reset_no_we", {63'h0, trap_csr_we}, 64'h0);
      rst = 1;
      cmp_en = 1;
      @(posedge clk); #1;
      check("reset_no_mcause", 64'(mcause_cnt), 64'(c_mcause));
      check("reset_idle", {63'h0, busy}, 64'h0);
    end

    do_event(0, 1, 0, 0, 0, 32'h8000_0600, 32'h8000_0604, 64'h8000_0040, 64'h8000_1000, 0);
    check("post_reset_mret", {32'h0, redir_seen}, 64'h8000_0040);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
